// File: rtl/emc_pkg.sv
// rtl/emc_pkg.sv - shared types and constants for the external code ROM responder
package emc_pkg;

    localparam int unsigned INT_ROM_SIZE_DEFAULT = 4096;
    localparam logic [7:0]  P0_DRIVE_MASK        = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DRIVE,
        ST_SKIP,
        ST_DRAIN
    } xrom_state_e;

endpackage

// File: rtl/emc_xrom_responder_if.sv
// rtl/emc_xrom_responder_if.sv - memory read channel between responder and code store
interface emc_xrom_responder_if;
    import emc_pkg::*;

    logic        req;
    logic [15:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [7:0]  rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/emc_sync2.sv
// rtl/emc_sync2.sv - two-flop synchronizer, resets to 1 (pad idle level)
module emc_sync2 (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/emc_xrom_responder.sv
// rtl/emc_xrom_responder.sv - serves MCU external code fetches on P0 from a memory read port
module emc_xrom_responder
    import emc_pkg::*;
#(
    parameter int unsigned INT_ROM_SIZE = INT_ROM_SIZE_DEFAULT
) (
    input  logic        xrom_clock_i,
    input  logic        xrom_reset_b_i,
    input  logic        xrom_psen_b_i,
    input  logic        xrom_ea_b_i,
    input  logic [7:0]  xrom_p0_y_i,
    input  logic [7:0]  xrom_p2_y_i,
    output logic [7:0]  xrom_p0_a_o,
    output logic [7:0]  xrom_p0_en_o,
    output logic        xrom_mem_req_o,
    output logic [15:0] xrom_mem_addr_o,
    input  logic        xrom_mem_gnt_i,
    input  logic        xrom_mem_rvalid_i,
    input  logic [7:0]  xrom_mem_rdata_i,
    input  logic        xrom_clr_i,
    output logic        xrom_busy_o,
    output logic        xrom_miss_o,
    output logic [15:0] xrom_fetch_cnt_o
);

    xrom_state_e state, state_next;
    logic        psen_s, psen_d;
    logic        fall, rise;
    logic [15:0] addr_q, fetch_addr;
    logic [7:0]  data_q;
    logic        abort_q, abort_next;
    logic        capture, set_miss, inc_cnt;
    logic        miss;
    logic [15:0] fetch_cnt;

    emc_sync2 u_sync (
        .clk    (xrom_clock_i),
        .resetn (xrom_reset_b_i),
        .d      (xrom_psen_b_i),
        .q      (psen_s)
    );

    assign fall = psen_d & ~psen_s;
    assign rise = ~psen_d & psen_s;

    always_comb begin
        state_next = state;
        abort_next = 1'b0;
        capture    = 1'b0;
        set_miss   = 1'b0;
        inc_cnt    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (fall) begin
                    if (!xrom_ea_b_i || ({16'd0, addr_q} >= INT_ROM_SIZE)) state_next = ST_REQ;
                    else                                                   state_next = ST_SKIP;
                end
            end
            ST_REQ: begin
                // An abort cannot withdraw the request; it only redirects where the grant leads.
                set_miss = rise;
                if (xrom_mem_gnt_i) begin
                    if (abort_q || rise) begin
                        state_next = xrom_mem_rvalid_i ? ST_IDLE : ST_DRAIN;
                    end else if (xrom_mem_rvalid_i) begin
                        capture    = 1'b1;
                        state_next = ST_DRIVE;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end else begin
                    abort_next = abort_q | rise;
                end
            end
            ST_WAIT: begin
                if (rise) begin
                    set_miss   = 1'b1;
                    state_next = xrom_mem_rvalid_i ? ST_IDLE : ST_DRAIN;
                end else if (xrom_mem_rvalid_i) begin
                    capture    = 1'b1;
                    state_next = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (rise) begin
                    inc_cnt    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_SKIP:  if (rise) state_next = ST_IDLE;
            ST_DRAIN: if (xrom_mem_rvalid_i) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge xrom_clock_i) begin
        if (!xrom_reset_b_i) begin
            state      <= ST_IDLE;
            psen_d     <= 1'b1;
            addr_q     <= 16'h0000;
            fetch_addr <= 16'h0000;
            data_q     <= 8'h00;
            abort_q    <= 1'b0;
            miss       <= 1'b0;
            fetch_cnt  <= 16'h0000;
        end else begin
            state   <= state_next;
            psen_d  <= psen_s;
            abort_q <= abort_next;
            // Pads carry the address only while PSEN_B is high, so freeze it on the edge.
            if (psen_s) addr_q <= {xrom_p2_y_i, xrom_p0_y_i};
            if (state == ST_IDLE && fall) fetch_addr <= addr_q;
            if (capture) data_q <= xrom_mem_rdata_i;
            if (xrom_clr_i) begin
                miss      <= 1'b0;
                fetch_cnt <= 16'h0000;
            end else begin
                if (set_miss) miss <= 1'b1;
                if (inc_cnt && fetch_cnt != 16'hFFFF) fetch_cnt <= fetch_cnt + 16'd1;
            end
        end
    end

    assign xrom_p0_en_o     = (state == ST_DRIVE) ? P0_DRIVE_MASK : 8'h00;
    assign xrom_p0_a_o      = (state == ST_DRIVE) ? data_q : 8'h00;
    assign xrom_mem_req_o   = (state == ST_REQ);
    assign xrom_mem_addr_o  = fetch_addr;
    assign xrom_busy_o      = (state != ST_IDLE);
    assign xrom_miss_o      = miss;
    assign xrom_fetch_cnt_o = fetch_cnt;

endmodule

// File: tb/tb_emc_xrom_responder.sv
// tb/tb_emc_xrom_responder.sv - randomized and directed bench for emc_xrom_responder
module tb_emc_xrom_responder;

    localparam int ROM_SIZE = 4096;

    logic        clk;
    logic        resetn;
    logic        psen_b;
    logic        ea_b;
    logic [7:0]  p0_y;
    logic [7:0]  p2_y;
    logic [7:0]  p0_a;
    logic [7:0]  p0_en;
    logic        clr;
    logic        busy;
    logic        miss;
    logic [15:0] fetch_cnt;

    emc_xrom_responder_if mem_if ();

    int n_tests = 0;
    int n_fail  = 0;
    bit         miss_m = 1'b0;
    logic [15:0] cnt_m = 16'h0000;

    emc_xrom_responder dut (
        .xrom_clock_i      (clk),
        .xrom_reset_b_i    (resetn),
        .xrom_psen_b_i     (psen_b),
        .xrom_ea_b_i       (ea_b),
        .xrom_p0_y_i       (p0_y),
        .xrom_p2_y_i       (p2_y),
        .xrom_p0_a_o       (p0_a),
        .xrom_p0_en_o      (p0_en),
        .xrom_mem_req_o    (mem_if.req),
        .xrom_mem_addr_o   (mem_if.addr),
        .xrom_mem_gnt_i    (mem_if.gnt),
        .xrom_mem_rvalid_i (mem_if.rvalid),
        .xrom_mem_rdata_i  (mem_if.rdata),
        .xrom_clr_i        (clr),
        .xrom_busy_o       (busy),
        .xrom_miss_o       (miss),
        .xrom_fetch_cnt_o  (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        psen_b        = 1'b1;
        mem_if.gnt    = 1'b0;
        mem_if.rvalid = 1'b0;
        mem_if.rdata  = 8'h00;
        clr           = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        check_eq({tag, " miss"}, miss, miss_m);
        check_eq({tag, " cnt"}, fetch_cnt, cnt_m);
    endtask

    // Cycle 0 drives PSEN_B low; the fall reaches the FSM two cycles later, so the fetch
    // starts in cycle 3. g/v/x are the gnt, rvalid and stray-rvalid cycles, r the PSEN_B
    // rise cycle, k the clr cycle (-1 = none).
    task automatic run_fetch(input bit ea_v, input logic [15:0] addr_v, input logic [7:0] data_v,
                             input int g, input int v, input int r, input int x, input int k);
        bit ext, abort, exp_req, exp_en, exp_busy;
        int rr, last;
        ext   = !ea_v || (int'(addr_v) >= ROM_SIZE);
        rr    = r + 2;
        abort = ext && (rr <= v);
        last  = (ext && abort) ? v : rr;
        idle_inputs();
        ea_b = ea_v;
        {p2_y, p0_y} = addr_v;
        repeat (3) @(negedge clk);
        for (int c = 0; c <= last + 3; c++) begin
            @(negedge clk);
            exp_busy = (c >= 3) && (c <= last);
            exp_req  = ext && (c >= 3) && (c <= g);
            exp_en   = ext && !abort && (c >= v + 1) && (c <= rr);
            check_eq($sformatf("busy %04h c%0d", addr_v, c), busy, exp_busy);
            check_eq($sformatf("req %04h c%0d", addr_v, c), mem_if.req, exp_req);
            if (exp_req) check_eq($sformatf("addr %04h c%0d", addr_v, c), mem_if.addr, addr_v);
            check_eq($sformatf("en %04h c%0d", addr_v, c), p0_en, exp_en ? 8'hFF : 8'h00);
            check_eq($sformatf("p0 %04h c%0d", addr_v, c), p0_a, exp_en ? data_v : 8'h00);
            psen_b        = (c >= r);
            mem_if.gnt    = ext && (c == g);
            mem_if.rvalid = (c == v) || (c == x);
            mem_if.rdata  = (c == v) ? data_v : 8'($urandom);
            clr           = (c == k);
            if (c > r) {p2_y, p0_y} = 16'($urandom);
        end
        idle_inputs();
        if (k >= 0 && k < rr) begin
            miss_m = 1'b0;
            cnt_m  = 16'h0000;
        end
        if (ext && abort) miss_m = 1'b1;
        if (ext && !abort && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
        if (k >= rr) begin
            miss_m = 1'b0;
            cnt_m  = 16'h0000;
        end
        @(negedge clk);
        check_counters($sformatf("end %04h", addr_v));
    endtask

    initial begin
        bit          ea_v;
        logic [15:0] addr_v;
        int          g, v, r, x, k, sel;

        resetn = 1'b0;
        ea_b   = 1'b0;
        p0_y   = 8'h00;
        p2_y   = 8'h00;
        idle_inputs();
        repeat (3) @(negedge clk);
        check_eq("rst busy", busy, 1'b0);
        check_eq("rst req", mem_if.req, 1'b0);
        check_eq("rst addr", mem_if.addr, 16'h0000);
        check_eq("rst en", p0_en, 8'h00);
        check_eq("rst p0", p0_a, 8'h00);
        check_counters("rst");
        resetn = 1'b1;

        run_fetch(1'b0, 16'h1234, 8'hA5, 4, 5, 8, -1, -1);
        check_eq("first fetch cnt", fetch_cnt, 16'd1);
        run_fetch(1'b1, 16'h0800, 8'h3C, -1, -1, 4, 4, -1);
        run_fetch(1'b1, 16'h1000, 8'h5A, 3, 4, 5, -1, -1);
        run_fetch(1'b0, 16'h2222, 8'h77, 3, 8, 3, -1, -1);
        run_fetch(1'b0, 16'h2223, 8'h88, 3, 4, 4, -1, -1);
        run_fetch(1'b0, 16'h3333, 8'h99, 3, 5, 3, 6, -1);
        run_fetch(1'b0, 16'h4444, 8'h11, 7, 9, 1, -1, -1);

        // Reset while driving P0: everything idles and the counters clear without a miss.
        idle_inputs();
        ea_b = 1'b0;
        {p2_y, p0_y} = 16'h5555;
        repeat (3) @(negedge clk);
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            psen_b        = 1'b0;
            mem_if.gnt    = (c == 3);
            mem_if.rvalid = (c == 4);
            mem_if.rdata  = 8'hC3;
        end
        @(negedge clk);
        check_eq("pre-rst en", p0_en, 8'hFF);
        check_eq("pre-rst p0", p0_a, 8'hC3);
        resetn = 1'b0;
        idle_inputs();
        @(negedge clk);
        miss_m = 1'b0;
        cnt_m  = 16'h0000;
        check_eq("mid-rst en", p0_en, 8'h00);
        check_eq("mid-rst req", mem_if.req, 1'b0);
        check_eq("mid-rst busy", busy, 1'b0);
        check_counters("mid-rst");
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("post-rst busy", busy, 1'b0);

        @(negedge clk);
        force dut.fetch_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.fetch_cnt;
        cnt_m = 16'hFFFF;
        run_fetch(1'b0, 16'h6000, 8'h42, 3, 4, 5, -1, -1);
        run_fetch(1'b1, 16'h7000, 8'h24, 3, 4, 5, -1, 7);
        check_eq("clr vs inc cnt", fetch_cnt, 16'h0000);

        for (int i = 0; i < 40; i++) begin
            ea_v = 1'($urandom_range(0, 1));
            sel  = int'($urandom_range(0, 3));
            case (sel)
                0:       addr_v = 16'($urandom_range(0, 4095));
                1:       addr_v = 16'($urandom_range(4096, 65535));
                2:       addr_v = 16'd4095;
                default: addr_v = 16'd4096;
            endcase
            if (!ea_v || int'(addr_v) >= ROM_SIZE) begin
                g = 3 + int'($urandom_range(0, 3));
                v = g + int'($urandom_range(0, 3));
                if ($urandom_range(0, 2) != 0) begin
                    r = v - 1 + int'($urandom_range(0, 4));
                    x = ($urandom_range(0, 1) != 0) ? int'($urandom_range(v + 1, r + 3)) : -1;
                end else begin
                    r = int'($urandom_range(1, v - 2));
                    x = -1;
                end
            end else begin
                g = -1;
                v = -1;
                r = int'($urandom_range(1, 6));
                x = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, r + 3)) : -1;
            end
            k = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, r + 3)) : -1;
            run_fetch(ea_v, addr_v, 8'($urandom), g, v, r, x, k);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/emc_xrom_responder.md
EMC_XROM_RESPONDER -- requirements
Module: emc_xrom_responder

Interface
REQ-001 SHALL have parameter INT_ROM_SIZE, default 4096, meaning first code address served externally when EA_B is high.
REQ-002 SHALL have ports in this order:
- xrom_clock_i  in  1  sole clock, all logic on rising edge.
- xrom_reset_b_i  in  1  reset, synchronous, active-low.
- xrom_psen_b_i  in  1  program store enable from MCU pad, asynchronous.
- xrom_ea_b_i  in  1  external access select from pad.
- xrom_p0_y_i  in  8  P0 pad value (low address).
- xrom_p2_y_i  in  8  P2 pad value (high address).
- xrom_p0_a_o  out  8  code byte driven onto P0.
- xrom_p0_en_o  out  8  per-bit P0 drive enable, 1 = drive.
- xrom_mem_req_o  out  1  memory read request.
- xrom_mem_addr_o  out  16  memory read address.
- xrom_mem_gnt_i  in  1  request accepted.
- xrom_mem_rvalid_i  in  1  read data valid.
- xrom_mem_rdata_i  in  8  read data.
- xrom_clr_i  in  1  clears miss flag and fetch counter.
- xrom_busy_o  out  1  state is not IDLE.
- xrom_miss_o  out  1  sticky: fetch aborted before data was driven.
- xrom_fetch_cnt_o  out  16  completed fetches, saturating.

Function
REQ-003 SHALL pass xrom_psen_b_i through a 2-flop synchronizer; a falling or rising edge is detected from the synchronized value and its 1-cycle delay.
REQ-004 SHALL register {p2_y, p0_y} every cycle while synchronized PSEN_B is high; on a detected falling edge this registered value is the fetch address.
REQ-005 SHALL have states IDLE, REQ, WAIT, DRIVE, SKIP, DRAIN.
REQ-006 IDLE, falling edge: if ea_b==0 or address>=INT_ROM_SIZE go to REQ, else go to SKIP.
REQ-007 REQ: mem_req_o=1 and mem_addr_o=address, held stable until gnt; on gnt go to WAIT, or go to DRIVE if rvalid in the same cycle.
REQ-008 WAIT: on rvalid capture rdata and go to DRIVE.
REQ-009 DRIVE: p0_a_o=captured byte and p0_en_o=8'hFF, starting the cycle after capture, until a rising edge is detected; then go to IDLE, deassert en in the next cycle, and increment fetch_cnt, saturating at 16'hFFFF.
REQ-010 Rising edge in REQ: set miss, keep req asserted until gnt, then go to DRAIN (or to IDLE if rvalid in the gnt cycle).
REQ-011 Rising edge in WAIT: set miss and go to DRAIN. If rvalid arrives in the same cycle, the rising edge wins: drop the data and go to IDLE.
REQ-012 DRAIN: discard the first rvalid, go to IDLE; p0_en_o stays 0.
REQ-013 SKIP: never drive P0 or request memory; return to IDLE on a rising edge.
REQ-014 rvalid in IDLE, SKIP or DRIVE SHALL be ignored.
REQ-015 A falling edge is only acted on in IDLE; a new fetch needs a rising edge first.
REQ-016 p0_en_o SHALL be 0 in every state except DRIVE; p0_a_o SHALL be 8'h00 while en is 0.
REQ-017 clr_i SHALL zero miss and fetch_cnt next cycle. If clr_i coincides with a set or increment event, clr_i wins.
REQ-018 busy_o = (state != IDLE), registered.

Reset
REQ-019 While xrom_reset_b_i==0 at a clock edge: state=IDLE, both synchronizer flops=1, p0_en_o=0, p0_a_o=0, mem_req_o=0, mem_addr_o=0, miss=0, fetch_cnt=0, busy=0.
REQ-020 A reset in any state, including mid-fetch, SHALL abort without setting miss. The memory side shares the same reset.

Structure
REQ-021 The shared package emc_pkg SHALL hold the state enum type, the default INT_ROM_SIZE, and the value 8'hFF for the P0 drive-enable mask.
REQ-022 The synchronizer SHALL be the sub-module emc_sync2 (2 flops, reset value 1).

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- ea_b=0, P2/P0=12h/34h, PSEN_B low, gnt +1, rvalid +2 with A5h -> mem_addr 1234h, P0 driven A5h with en FFh until 1 cycle after PSEN_B rise, fetch_cnt 1.
- ea_b=1, address 0800h -> SKIP, no req, en stays 0. ea_b=1, address 1000h -> external fetch.
- PSEN_B rises while in WAIT, rvalid 3 cycles later -> miss=1, rvalid drained, en never 1, fetch_cnt unchanged, next fetch serves correct data.
- rvalid in the same cycle as the PSEN_B rise -> data dropped, miss=1, state IDLE.
- Reset asserted in DRIVE -> en=0 and req=0 at the next edge, miss=0, fetch_cnt=0.
- fetch_cnt preset to FFFFh plus one fetch -> stays FFFFh; clr_i in the same cycle as an increment -> 0.
